// File: rtl/game_pkg.sv
// Shared game-timing types and default constants for the scheduler,
// obstacle and render blocks.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam int unsigned PIX_DIV_DEF      = 4;
  localparam int unsigned MOVE_PERIOD0_DEF = 2_000_000;
  localparam int unsigned MOVE_STEP_DEF    = 100_000;
  localparam int unsigned MOVE_MIN_DEF     = 500_000;
  localparam int unsigned LEVEL_TICKS_DEF  = 256;
  localparam int unsigned CW_DEF           = 24;
  localparam int unsigned LVL_W            = 4;
  localparam int unsigned LVL_MAX          = 15;

endpackage

// File: rtl/tick_gen.sv
// Period counter producing a registered one-cycle tick. en/clr/period describe
// the upcoming cycle so the tick can be registered without losing alignment.
module tick_gen
  import game_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] period,
  output logic          tick
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q;
  logic          tick_q;

  // act_q: the current cycle advances the count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (act_q) begin
      cnt_d = (cnt_q >= period - CW'(1)) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    act_q <= en;
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= en && (cnt_d == period - CW'(1));
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_tick_sched.sv
// Game run-state FSM plus pixel and obstacle-move enable pulses; the move
// period shrinks one step every LEVEL_TICKS moves down to a floor.
module game_tick_sched
  import game_pkg::*;
#(
  parameter int unsigned PIX_DIV      = PIX_DIV_DEF,
  parameter int unsigned MOVE_PERIOD0 = MOVE_PERIOD0_DEF,
  parameter int unsigned MOVE_STEP    = MOVE_STEP_DEF,
  parameter int unsigned MOVE_MIN     = MOVE_MIN_DEF,
  parameter int unsigned LEVEL_TICKS  = LEVEL_TICKS_DEF,
  parameter int unsigned CW           = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause_tgl,
  input  logic          crash,
  output logic          pix_en,
  output logic          move_en,
  output logic [3:0]    level,
  output logic [1:0]    state,
  output logic [CW-1:0] move_period
);

  localparam int unsigned LC_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

  game_state_e      state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CW-1:0]    period_q, period_d;
  logic [LC_W-1:0]  lvl_cnt_q, lvl_cnt_d;
  logic             reload;
  logic             run_d;
  logic             pix_tick;
  logic             move_tick;

  // Next run state; crash outranks pause_tgl
  always_comb begin
    state_d = state_q;
    reload  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          reload  = 1'b1;
        end
      end
      ST_RUN: begin
        if (crash)          state_d = ST_OVER;
        else if (pause_tgl) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (crash)          state_d = ST_OVER;
        else if (pause_tgl) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Level progression and move-period speed-up on each completed move
  always_comb begin
    level_d   = level_q;
    period_d  = period_q;
    lvl_cnt_d = lvl_cnt_q;
    if (reload) begin
      level_d   = '0;
      period_d  = CW'(MOVE_PERIOD0);
      lvl_cnt_d = '0;
    end else if (move_tick) begin
      if (lvl_cnt_q == LC_W'(LEVEL_TICKS - 1)) begin
        lvl_cnt_d = '0;
        if (level_q != LVL_W'(LVL_MAX)) level_d = level_q + LVL_W'(1);
        period_d = (32'(period_q) >= MOVE_MIN + MOVE_STEP) ?
                   period_q - CW'(MOVE_STEP) : CW'(MOVE_MIN);
      end else begin
        lvl_cnt_d = lvl_cnt_q + LC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      period_q  <= CW'(MOVE_PERIOD0);
      lvl_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      period_q  <= period_d;
      lvl_cnt_q <= lvl_cnt_d;
    end
  end

  assign run_d = rst_n && (state_d == ST_RUN);

  tick_gen #(.CW(CW)) u_pix (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .clr    (1'b0),
    .period (CW'(PIX_DIV)),
    .tick   (pix_tick)
  );

  // Fed with next-cycle state/period so move_en stays registered yet aligned
  tick_gen #(.CW(CW)) u_move (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run_d),
    .clr    (reload),
    .period (period_d),
    .tick   (move_tick)
  );

  assign pix_en      = pix_tick;
  assign move_en     = move_tick;
  assign level       = level_q;
  assign state       = state_q;
  assign move_period = period_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Bench for game_tick_sched: directed scenarios plus random play, checked
// every cycle against a cycle-level reference model of the game rules.
module tb_game_tick_sched;

  localparam int PIX  = 4;
  localparam int MP0  = 20;
  localparam int STEP = 5;
  localparam int MMIN = 8;
  localparam int LT   = 4;
  localparam int CW   = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause_tgl = 1'b0;
  logic          crash = 1'b0;
  logic          pix_en, move_en;
  logic [3:0]    level;
  logic [1:0]    state;
  logic [CW-1:0] move_period;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model: values in force during the current cycle
  int m_st = 0, m_cnt = 0, m_per = MP0, m_lvl = 0, m_lc = 0, m_pix = 0;

  game_tick_sched #(
    .PIX_DIV(PIX), .MOVE_PERIOD0(MP0), .MOVE_STEP(STEP),
    .MOVE_MIN(MMIN), .LEVEL_TICKS(LT), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause_tgl(pause_tgl),
    .crash(crash), .pix_en(pix_en), .move_en(move_en), .level(level),
    .state(state), .move_period(move_period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : ref_model
    int st, cnt, per, lvl, lc, pix;
    bit mv, enter;
    st = m_st; cnt = m_cnt; per = m_per; lvl = m_lvl; lc = m_lc; pix = m_pix;
    if (!rst_n) begin
      st = 0; cnt = 0; per = MP0; lvl = 0; lc = 0; pix = 0;
    end else begin
      mv  = (st == 1) && (cnt == per - 1);
      pix = (pix == PIX - 1) ? 0 : pix + 1;
      if (st == 1) cnt = mv ? 0 : cnt + 1;
      if (mv) begin
        lc = lc + 1;
        if (lc == LT) begin
          lc  = 0;
          lvl = (lvl < 15) ? lvl + 1 : 15;
          per = (per - STEP < MMIN) ? MMIN : per - STEP;
        end
      end
      enter = 1'b0;
      case (st)
        0, 3: if (start) begin st = 1; enter = 1'b1; end
        1: if (crash) st = 3; else if (pause_tgl) st = 2;
        2: if (crash) st = 3; else if (pause_tgl) st = 1;
        default: st = 0;
      endcase
      if (enter) begin lvl = 0; per = MP0; cnt = 0; lc = 0; end
    end
    m_st <= st; m_cnt <= cnt; m_per <= per; m_lvl <= lvl; m_lc <= lc; m_pix <= pix;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_state",  32'(state),       32'(m_st));
      check("mon_level",  32'(level),       32'(m_lvl));
      check("mon_period", 32'(move_period), 32'(m_per));
      check("mon_move",   32'(move_en),     32'((m_st == 1) && (m_cnt == m_per - 1)));
      check("mon_pix",    32'(pix_en),      32'(m_pix == PIX - 1));
    end
  end

  initial begin
    int n;
    // Reset held three cycles
    step(); mon_en = 1'b1;
    step(); step();
    check("rst_state", 32'(state), 0);
    check("rst_level", 32'(level), 0);
    check("rst_period", 32'(move_period), MP0);
    check("rst_move", 32'(move_en), 0);
    check("rst_pix", 32'(pix_en), 0);
    rst_n = 1'b1;

    // Idle: pixel pulses every 4 cycles, never a move
    for (int c = 1; c <= 100; c++) begin
      if (c <= 12) check("pix_phase", 32'(pix_en), 32'(c % 4 == 0));
      check("idle_move", 32'(move_en), 0);
      step();
    end

    // First game: moves at 20/40/60/80, then period 15
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 139; k++) begin
      if (k == 1) check("run_entry", 32'(state), 1);
      check("run_move", 32'(move_en),
            32'(k == 20 || k == 40 || k == 60 || k == 80 || k == 95 || k == 110 || k == 125));
      if (k == 81) begin
        check("lvl1_level", 32'(level), 1);
        check("lvl1_period", 32'(move_period), 15);
      end
      if (k == 139) begin crash = 1'b1; pause_tgl = 1'b1; end
      step();
    end
    crash = 1'b0; pause_tgl = 1'b0;
    // Crash + pause + due move in the same cycle
    check("crash_state", 32'(state), 3);
    check("crash_move", 32'(move_en), 0);
    check("crash_level", 32'(level), 1);
    check("crash_period", 32'(move_period), 15);
    pause_tgl = 1'b1; step(); pause_tgl = 1'b0;
    crash = 1'b1; step(); crash = 1'b0;
    step();
    check("over_hold", 32'(state), 3);
    check("over_level", 32'(level), 1);

    // Restart reloads level and period
    start = 1'b1; step(); start = 1'b0;
    check("restart_state", 32'(state), 1);
    check("restart_level", 32'(level), 0);
    check("restart_period", 32'(move_period), MP0);

    // Pause after 10 RUN cycles, hold 50 cycles, resume
    for (int k = 1; k < 10; k++) step();
    pause_tgl = 1'b1; step(); pause_tgl = 1'b0;
    check("pause_state", 32'(state), 2);
    for (int i = 1; i <= 50; i++) begin
      check("pause_move", 32'(move_en), 0);
      check("pause_hold", 32'(state), 2);
      start     = (i == 20);
      pause_tgl = (i == 50);
      step();
    end
    start = 1'b0; pause_tgl = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      if (j == 1) check("resume_state", 32'(state), 1);
      check("resume_move", 32'(move_en), 32'(j == 10));
      step();
    end

    // Long run until level saturates
    n = 0;
    while (level != 4'd15 && n < 3000) begin step(); n++; end
    check("sat_reached", 32'(level), 15);
    check("sat_period", 32'(move_period), MMIN);
    for (int i = 0; i < 200; i++) step();
    check("sat_level_hold", 32'(level), 15);
    check("sat_period_hold", 32'(move_period), MMIN);

    // Reset pulse at RUN cycle 37
    crash = 1'b1; step(); crash = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k < 37; k++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("midrst_state", 32'(state), 0);
    check("midrst_level", 32'(level), 0);
    check("midrst_period", 32'(move_period), MP0);
    check("midrst_move", 32'(move_en), 0);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      check("post_rst_move", 32'(move_en), 32'(k == 20));
      step();
    end

    // Random play checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      start     = ($urandom_range(0, 39) == 0);
      pause_tgl = ($urandom_range(0, 29) == 0);
      crash     = ($urandom_range(0, 249) == 0);
      step();
    end
    rst_n = 1'b1; start = 1'b0; pause_tgl = 1'b0; crash = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
